serial_tx: RTL and testbench
============================

SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of data bits per frame (>=1).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 4, clock cycles each serial bit is held (>=1).
REQ-003 SHALL have port Clk  input  1  sole clock; all state updates on posedge Clk.
REQ-004 SHALL have port Rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port Din  input  WIDTH  parallel word to transmit.
REQ-006 SHALL have port Load  input  1  request to send Din.
REQ-007 SHALL have port Ready  output  1  high when a Load will be accepted.
REQ-008 SHALL have port Dout  output  1  serial line; idle level 1.
REQ-009 SHALL have port Busy  output  1  high while a frame is in progress.
REQ-010 SHALL have port Done  output  1  one-cycle pulse at frame completion.
REQ-011 SHALL register all outputs; no combinational input-to-output path.

Function
REQ-012 SHALL implement the FSM states IDLE, START, DATA, STOP.
REQ-013 Frame SHALL be: start bit 0, WIDTH data bits LSB first, stop bit 1; total (WIDTH+2)*CLKS_PER_BIT cycles.
REQ-014 Handshake: Load accepted only at a posedge where Load=1 and Ready=1; Din latched into the shift register at that edge.
REQ-015 Load while Ready=0 SHALL be ignored; Din changes after acceptance SHALL NOT affect the frame.
REQ-016 After the accepting edge: IDLE->START; Ready=0, Busy=1, Dout=0 from the next cycle.
REQ-017 Each bit SHALL be held exactly CLKS_PER_BIT cycles via a bit-timer counter sized ceil(log2(CLKS_PER_BIT))+1 bits.
REQ-018 START->DATA after CLKS_PER_BIT cycles; DATA SHALL shift out WIDTH bits, tracked by a bit index counter.
REQ-019 DATA->STOP after the WIDTH-th bit completes; STOP drives Dout=1 for CLKS_PER_BIT cycles.
REQ-020 STOP->IDLE at stop-bit end; in that first IDLE cycle Done=1, Ready=1, Busy=0, Dout=1.
REQ-021 Done SHALL be high for exactly one cycle per frame and never otherwise.
REQ-022 Back-to-back: Load=1 in the Done cycle SHALL be accepted; next start bit begins the following cycle (exactly one idle cycle between frames).
REQ-023 CLKS_PER_BIT=1 SHALL yield one cycle per bit with no lost or duplicated bits.
REQ-024 In IDLE Dout SHALL remain 1 regardless of Din.

Reset
REQ-025 At a posedge with Rst_n=0: state=IDLE, Dout=1, Ready=1, Busy=0, Done=0, counters and shift register cleared.
REQ-026 Reset mid-frame SHALL abort the frame immediately at that edge with no Done pulse; the partial frame is not resumed.
REQ-027 Load coincident with Rst_n=0 SHALL be ignored.
REQ-028 Rst_n has no effect between clock edges.

Verification
REQ-029 Defaults, Load=1 with Din=8'hA5 for one cycle from IDLE -> Dout bits 0,1,0,1,0,0,1,0,1,1 each 4 cycles; Done one cycle, 41 cycles after the accepting edge.
REQ-030 Load held high continuously with Din=8'h00 then 8'hFF -> two frames separated by exactly one idle cycle, two Done pulses, correct bits.
REQ-031 Load pulsed at cycle 10 of a frame with a different Din -> ignored; frame unchanged; Ready stays 0 until Done.
REQ-032 Rst_n=0 for one cycle during DATA -> next cycle Dout=1, Ready=1, Busy=0, no Done; next Load sends a full correct frame.
REQ-033 CLKS_PER_BIT=1, WIDTH=4, Din=4'b1001 -> Dout 0,1,0,0,1,1 on consecutive cycles, Done on cycle 7 after accept.
REQ-034 Checker SHALL assert each cycle: Busy == !Ready, Done implies Ready, Dout=1 whenever state is IDLE.

Source files
------------

// File: rtl/serial_tx.sv
// serial_tx: parallel-to-serial frame transmitter.
// Frame = start bit (0), WIDTH data bits LSB first, stop bit (1); each bit is
// held for CLKS_PER_BIT clocks. Every output comes straight from a flop.
module serial_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [WIDTH-1:0] Din,
    input  logic             Load,
    output logic             Ready,
    output logic             Dout,
    output logic             Busy,
    output logic             Done
);

    localparam int TW = $clog2(CLKS_PER_BIT) + 1;
    localparam int IW = $clog2(WIDTH) + 1;
    localparam logic [TW-1:0] TMR_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_nxt;
    logic [TW-1:0]    bit_tmr;
    logic [IW-1:0]    bit_idx;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic             accept, bit_end, last_bit;
    logic             dout_nxt, ready_nxt, busy_nxt, done_nxt;

    // Ready is a flop that tracks IDLE, so the handshake has no comb path to outputs.
    assign accept   = Load & Ready;
    assign bit_end  = (bit_tmr == TMR_LAST);
    assign last_bit = (bit_idx == IDX_LAST);

    // State register.
    always_ff @(posedge Clk) begin
        if (!Rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: each non-idle state lasts whole bit periods.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)              state_nxt = START;
            START:   if (bit_end)             state_nxt = DATA;
            DATA:    if (bit_end && last_bit) state_nxt = STOP;
            STOP:    if (bit_end)             state_nxt = IDLE;
            default:                          state_nxt = IDLE;
        endcase
    end

    // Next shift-register value: load on accept, shift once per finished data bit.
    always_comb begin
        shreg_nxt = shreg;
        if (state == IDLE && accept)      shreg_nxt = Din;
        else if (state == DATA && bit_end) shreg_nxt = shreg >> 1;
    end

    // Bit timer, bit index and shift register.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            bit_tmr <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (state == IDLE || bit_end) bit_tmr <= '0;
            else                          bit_tmr <= bit_tmr + 1'b1;

            if (state != DATA) bit_idx <= '0;
            else if (bit_end)  bit_idx <= bit_idx + 1'b1;

            shreg <= shreg_nxt;
        end
    end

    // Output decode from the upcoming state, so the registered outputs line up with it.
    always_comb begin
        dout_nxt  = 1'b1;
        ready_nxt = 1'b0;
        busy_nxt  = 1'b1;
        done_nxt  = 1'b0;
        case (state_nxt)
            IDLE: begin
                ready_nxt = 1'b1;
                busy_nxt  = 1'b0;
                done_nxt  = (state == STOP);
            end
            START:   dout_nxt = 1'b0;
            DATA:    dout_nxt = shreg_nxt[0];
            STOP:    dout_nxt = 1'b1;
            default: dout_nxt = 1'b1;
        endcase
    end

    // Output register.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            Dout  <= 1'b1;
            Ready <= 1'b1;
            Busy  <= 1'b0;
            Done  <= 1'b0;
        end else begin
            Dout  <= dout_nxt;
            Ready <= ready_nxt;
            Busy  <= busy_nxt;
            Done  <= done_nxt;
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: a default instance (WIDTH=8, CLKS_PER_BIT=4) and a
// fast instance (WIDTH=4, CLKS_PER_BIT=1). Stimulus pushes hand-computed
// frames (bit i = i-th transmitted bit); a negedge monitor rebuilds frames
// from Dout and compares at each Done.
module tb_serial_tx;

    logic       clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       loadA = 1'b0, loadB = 1'b0;
    logic [7:0] dinA = '0;
    logic [3:0] dinB = '0;
    logic       readyA, doutA, busyA, doneA;
    logic       readyB, doutB, busyB, doneB;

    int vectors = 0;
    int miscompares = 0;
    logic mon_en = 1'b0;
    logic rst_at_edge;

    logic [15:0] qa[$];
    logic [15:0] qb[$];
    int          bcnt  [2];
    logic [15:0] frame [2];
    logic        pbusy [2];

    always #5 clk = ~clk;

    serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) dut_a (
        .Clk(clk), .Rst_n(Rst_n), .Din(dinA), .Load(loadA),
        .Ready(readyA), .Dout(doutA), .Busy(busyA), .Done(doneA));

    serial_tx #(.WIDTH(4), .CLKS_PER_BIT(1)) dut_b (
        .Clk(clk), .Rst_n(Rst_n), .Din(dinB), .Load(loadB),
        .Ready(readyB), .Dout(doutB), .Busy(busyB), .Done(doneB));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reset as seen by the design at the most recent edge.
    always @(posedge clk) rst_at_edge = Rst_n;

    task automatic mon(input int id, input int cpb, input int w,
                       input logic rdy, input logic busy, input logic done, input logic dout);
        logic [15:0] e;
        int k;
        if (!rst_at_edge) begin
            check("reset_ready", rdy, 1);
            check("reset_busy", busy, 0);
            check("reset_done", done, 0);
            check("reset_dout", dout, 1);
            bcnt[id] = 0;
            pbusy[id] = 1'b0;
            if (id == 0) qa.delete(); else qb.delete();
            return;
        end
        check("busy_eq_not_ready", busy, !rdy);
        if (done) check("done_implies_ready", rdy, 1);
        if (rdy)  check("idle_dout_high", dout, 1);
        if (busy) begin
            k = bcnt[id] / cpb;
            if (bcnt[id] == 0) frame[id] = '0;
            if (k < 16) begin
                if (bcnt[id] % cpb == 0) frame[id][k] = dout;
                else check("bit_hold", dout, frame[id][k]);
            end
            bcnt[id]++;
        end
        if (done) begin
            e = '0;
            if (id == 0 && qa.size() > 0)      e = qa.pop_front();
            else if (id == 1 && qb.size() > 0) e = qb.pop_front();
            else begin
                vectors++;
                miscompares++;
                $display("FAIL scoreboard_empty dut%0d: Done with no frame expected", id);
            end
            check("done_after_frame", pbusy[id], 1);
            check("frame_bits", frame[id], e);
            check("frame_len", bcnt[id], (w + 2) * cpb);
            bcnt[id] = 0;
        end else if (pbusy[id] && !busy) begin
            check("done_at_frame_end", done, 1);
            bcnt[id] = 0;
        end
        pbusy[id] = busy;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0, 4, 8, readyA, busyA, doneA, doutA);
            mon(1, 1, 4, readyB, busyB, doneB, doutB);
        end
    end

    // Counts negedges after the accepting edge until Done shows (cycle 1 = start bit).
    task automatic wait_done(input int id, output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            n++;
            if ((id == 0) ? doneA : doneB) seen = 1'b1;
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout dut%0d: no Done within 200 cycles", id);
        end
    endtask

    task automatic send_a(input logic [7:0] d, input logic [15:0] exp);
        @(posedge clk); #1;
        loadA = 1'b1; dinA = d; qa.push_back(exp);
        @(posedge clk); #1;
        loadA = 1'b0; dinA = ~d;
    endtask

    task automatic send_b(input logic [3:0] d, input logic [15:0] exp);
        @(posedge clk); #1;
        loadB = 1'b1; dinB = d; qb.push_back(exp);
        @(posedge clk); #1;
        loadB = 1'b0; dinB = ~d;
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1 mon_en = 1'b1;
        @(posedge clk); #1 Rst_n = 1'b1;

        // Idle with wiggling Din: line stays high
        dinA = 8'hFF; dinB = 4'hF;
        repeat (3) @(posedge clk);
        #1 dinA = 8'h5A; dinB = 4'h3;
        repeat (2) @(posedge clk);

        // A5: 0,1,0,1,0,0,1,0,1,1 -> 10'h34A; Done in cycle 41
        send_a(8'hA5, 16'h034A);
        wait_done(0, n);
        check("a5_done_cycle", n, 41);

        // Load held: 00 then FF back-to-back with one idle cycle
        @(posedge clk); #1;
        loadA = 1'b1; dinA = 8'h00; qa.push_back(16'h0200);
        @(posedge clk); #1;
        dinA = 8'hFF; qa.push_back(16'h03FE);
        wait_done(0, n);
        check("b2b_first_done", n, 41);
        @(posedge clk); #1 loadA = 1'b0;
        @(negedge clk);
        check("b2b_start_next_cycle", busyA, 1);
        check("b2b_start_bit", doutA, 0);
        wait_done(0, n);
        check("b2b_second_done", n, 40);

        // Load during a frame is ignored: 96 -> 10'h32C
        send_a(8'h96, 16'h032C);
        repeat (10) @(posedge clk);
        #1 loadA = 1'b1; dinA = 8'h5A;
        @(posedge clk); #1 loadA = 1'b0;
        wait_done(0, n);
        check("ignored_load_done", n, 30);

        // Reset during DATA with Load asserted: frame aborted, Load ignored
        send_a(8'hC3, 16'h0386);
        repeat (15) @(posedge clk);
        #1 Rst_n = 1'b0; loadA = 1'b1; dinA = 8'hFF;
        @(posedge clk); #1 Rst_n = 1'b1; loadA = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("post_reset_ready", readyA, 1);
        check("post_reset_busy", busyA, 0);
        check("post_reset_done", doneA, 0);
        send_a(8'h3C, 16'h0278);
        wait_done(0, n);
        check("after_reset_done", n, 41);

        // One clock per bit: 1001 -> 0,1,0,0,1,1 -> 6'h32; Done in cycle 7
        send_b(4'b1001, 16'h0032);
        wait_done(1, n);
        check("fast_done_cycle", n, 7);

        // One clock per bit back-to-back: 0110 -> 6'h2C, 1111 -> 6'h3E
        @(posedge clk); #1;
        loadB = 1'b1; dinB = 4'b0110; qb.push_back(16'h002C);
        @(posedge clk); #1;
        dinB = 4'b1111; qb.push_back(16'h003E);
        wait_done(1, n);
        check("fast_b2b_first", n, 7);
        @(posedge clk); #1 loadB = 1'b0;
        wait_done(1, n);
        check("fast_b2b_second", n, 7);

        repeat (3) @(posedge clk);
        check("queue_a_drained", qa.size(), 0);
        check("queue_b_drained", qb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
